phase_freq_detector: RTL and testbench

Tri-state phase/frequency detector for the ADPLL loop. Samples the asynchronous reference and feedback clock inputs, detects their rising edges and emits the 2-bit count instruction (DISABLE/COUNT_UP/COUNT_DOWN) that drives the loop's up/down error counter. The instruction is held for exactly as many fpga_clk_i cycles as the measured edge separation. An optional lock detector reports sustained small phase error.

---
 rtl/adpll_pkg.sv | 30 +++
 rtl/edge_sync.sv | 39 +++
 rtl/phase_freq_detector.sv | 151 +++++++++++++++
 tb/tb_phase_freq_detector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// adpll_pkg: encodings shared across the ADPLL loop.
// The count-instruction encoding is common to the phase/frequency detector
// and the up/down error counter, so both ends decode the same values.
// Also holds the phase/frequency detector state encoding.
package adpll_pkg;

    localparam int unsigned COUNT_INSTR_W = 2;

    typedef enum logic [COUNT_INSTR_W-1:0] {
        CI_DISABLE    = 2'b00,
        CI_COUNT_UP   = 2'b01,
        CI_COUNT_DOWN = 2'b10
    } count_instr_e;

    typedef enum logic [1:0] {
        PFD_IDLE     = 2'b00,
        PFD_LEAD_REF = 2'b01,
        PFD_LEAD_FB  = 2'b10
    } pfd_state_e;

    // Moore decode: the leading clock selects the count direction.
    function automatic count_instr_e pfd_decode(input pfd_state_e s);
        case (s)
            PFD_LEAD_REF: pfd_decode = CI_COUNT_UP;
            PFD_LEAD_FB:  pfd_decode = CI_COUNT_DOWN;
            default:      pfd_decode = CI_DISABLE;
        endcase
    endfunction

endpackage

// File: rtl/edge_sync.sv
// edge_sync: synchronizes an asynchronous clock input and detects its
// rising edges as one-cycle pulses.
// Ports: fpga_clk_i (system clock), reset_n_i (async active-low reset),
//        async_i (asynchronous input), rise_o (one-cycle rising-edge pulse).
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic fpga_clk_i,
    input  logic reset_n_i,
    input  logic async_i,
    output logic rise_o
);

    localparam int unsigned MSB = SYNC_STAGES - 1;

    logic [MSB:0] sync_q;
    logic [MSB:0] valid_q;
    logic         last_q;
    logic         last_valid_q;

    // valid_q tracks which synchronizer stages hold a real sample since reset,
    // so a level already high at reset release is not reported as an edge.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q       <= '0;
            valid_q      <= '0;
            last_q       <= 1'b0;
            last_valid_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[MSB-1:0], async_i};
            valid_q      <= {valid_q[MSB-1:0], 1'b1};
            last_q       <= sync_q[MSB];
            last_valid_q <= valid_q[MSB];
        end
    end

    assign rise_o = sync_q[MSB] & ~last_q & last_valid_q;

endmodule

// File: rtl/phase_freq_detector.sv
// phase_freq_detector: tri-state phase/frequency detector for the ADPLL.
// Emits COUNT_UP while ref leads, COUNT_DOWN while fb leads, DISABLE otherwise;
// each instruction lasts as many cycles as the measured edge separation.
// Ports: fpga_clk_i, reset_n_i (async active-low), clear_i (sync clear),
//        ref_i / fb_i (asynchronous clocks), count_instr_o (2-bit instruction),
//        lock_o (loop-locked flag).
// Macro PFD_LOCK_DETECT_EN enables the lock detector; otherwise lock_o is 0.
module phase_freq_detector
    import adpll_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_WINDOW = 4,
    parameter int unsigned LOCK_COUNT  = 16
) (
    input  logic                     fpga_clk_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    input  logic                     ref_i,
    input  logic                     fb_i,
    output logic [COUNT_INSTR_W-1:0] count_instr_o,
    output logic                     lock_o
);

    logic       ref_rise;
    logic       fb_rise;
    pfd_state_e state;
    pfd_state_e next_state;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .fpga_clk_i (fpga_clk_i),
        .reset_n_i  (reset_n_i),
        .async_i    (ref_i),
        .rise_o     (ref_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .fpga_clk_i (fpga_clk_i),
        .reset_n_i  (reset_n_i),
        .async_i    (fb_i),
        .rise_o     (fb_rise)
    );

    // State register.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= PFD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a lone edge of the lagging clock ends the lead; a lone edge of
    // the leading clock is a cycle slip and keeps the lead.
    always_comb begin
        next_state = state;
        if (clear_i) begin
            next_state = PFD_IDLE;
        end else begin
            case (state)
                PFD_IDLE: begin
                    if (ref_rise && !fb_rise) begin
                        next_state = PFD_LEAD_REF;
                    end else if (fb_rise && !ref_rise) begin
                        next_state = PFD_LEAD_FB;
                    end
                end
                PFD_LEAD_REF: begin
                    if (fb_rise && !ref_rise) begin
                        next_state = PFD_IDLE;
                    end
                end
                PFD_LEAD_FB: begin
                    if (ref_rise && !fb_rise) begin
                        next_state = PFD_IDLE;
                    end
                end
                default: next_state = PFD_IDLE;
            endcase
        end
    end

    // Registered instruction; clear drops it on the very next edge.
    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_instr_o <= CI_DISABLE;
        end else if (clear_i) begin
            count_instr_o <= CI_DISABLE;
        end else begin
            count_instr_o <= pfd_decode(state);
        end
    end

`ifdef PFD_LOCK_DETECT_EN
    localparam int unsigned ERR_MAX = LOCK_WINDOW + 1;
    localparam int unsigned ERR_W   = $clog2(ERR_MAX + 1);
    localparam int unsigned GOOD_W  = $clog2(LOCK_COUNT + 1);

    logic [ERR_W-1:0]  err_cnt;
    logic [ERR_W-1:0]  err_inc;
    logic [ERR_W-1:0]  err_nxt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_inc;
    logic [GOOD_W-1:0] good_nxt;
    logic              leading;
    logic              win_close;

    // err_cnt holds the lead cycles already elapsed, so a window closing now
    // has an error of err_cnt+1 cycles.
    always_comb begin
        leading   = (state != PFD_IDLE);
        win_close = ((state == PFD_LEAD_REF) && fb_rise) ||
                    ((state == PFD_LEAD_FB)  && ref_rise);
        err_inc   = (err_cnt == ERR_W'(ERR_MAX)) ? err_cnt : err_cnt + ERR_W'(1);
        good_inc  = (good_cnt == GOOD_W'(LOCK_COUNT)) ? good_cnt : good_cnt + GOOD_W'(1);
        err_nxt   = '0;
        good_nxt  = good_cnt;
        if (clear_i) begin
            good_nxt = '0;
        end else if (leading) begin
            if (win_close) begin
                good_nxt = (err_cnt < ERR_W'(LOCK_WINDOW)) ? good_inc : '0;
            end else begin
                err_nxt = err_inc;
                if (err_inc == ERR_W'(ERR_MAX)) begin
                    good_nxt = '0;
                end
            end
        end else if (ref_rise && fb_rise) begin
            good_nxt = good_inc;
        end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_cnt  <= '0;
            good_cnt <= '0;
            lock_o   <= 1'b0;
        end else begin
            err_cnt  <= err_nxt;
            good_cnt <= good_nxt;
            lock_o   <= !clear_i && (good_cnt == GOOD_W'(LOCK_COUNT));
        end
    end
`else
    logic unused_lock_cfg;

    assign unused_lock_cfg = 1'(LOCK_WINDOW ^ LOCK_COUNT);
    assign lock_o          = 1'b0;
`endif

endmodule

// File: tb/tb_phase_freq_detector.sv
// tb_phase_freq_detector: scoreboard bench for phase_freq_detector.
// Stimulus pushes expected instruction pulses (code, start cycle, width) and
// lock transitions; a negedge monitor reassembles DUT pulses and compares.
module tb_phase_freq_detector;
    import adpll_pkg::*;

    typedef struct {
        logic [1:0] instr;
        int         start;
        int         width;
    } pulse_t;

    typedef struct {
        logic val;
        int   at;
    } lock_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clear  = 1'b0;
    logic       ref_in = 1'b1;
    logic       fb_in  = 1'b1;
    logic [1:0] instr;
    logic       lock;

    int     cyc    = 0;
    int     checks = 0;
    int     errors = 0;
    int     t0;
    pulse_t exp_q[$];
    lock_t  lock_q[$];

    phase_freq_detector #(
        .SYNC_STAGES (2),
        .LOCK_WINDOW (4),
        .LOCK_COUNT  (16)
    ) dut (
        .fpga_clk_i    (clk),
        .reset_n_i     (rst_n),
        .clear_i       (clear),
        .ref_i         (ref_in),
        .fb_i          (fb_in),
        .count_instr_o (instr),
        .lock_o        (lock)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_pulse(input logic [1:0] i, input int s, input int w);
        pulse_t p;
        p.instr = i;
        p.start = s;
        p.width = w;
        exp_q.push_back(p);
    endtask

    task automatic push_lock(input logic v, input int at);
        lock_t l;
        l.val = v;
        l.at  = at;
        lock_q.push_back(l);
    endtask

    task automatic finish_pulse(input logic [1:0] i, input int s, input int w);
        pulse_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: actual instr=%0d start=%0d width=%0d required none",
                     i, s, w);
        end else begin
            e = exp_q.pop_front();
            check("pulse_instr", int'(i), int'(e.instr));
            check("pulse_start", s, e.start);
            check("pulse_width", w, e.width);
        end
    endtask

    // Monitor: rebuild instruction pulses and lock transitions from the outputs.
    logic [1:0] prev_instr = 2'b00;
    logic       prev_lock  = 1'b0;
    int         p_start    = 0;
    int         p_width    = 0;

    always @(negedge clk) begin
        lock_t l;
        if (instr != prev_instr) begin
            if (prev_instr != 2'b00) finish_pulse(prev_instr, p_start, p_width);
            p_start = cyc;
            p_width = 0;
        end
        if (instr != 2'b00) p_width++;
        prev_instr = instr;
        if (lock != prev_lock) begin
            if (lock_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_lock: actual lock=%0d at cycle %0d required no change",
                         lock, cyc);
            end else begin
                l = lock_q.pop_front();
                check("lock_value", int'(lock), int'(l.val));
                check("lock_cycle", cyc, l.at);
            end
            prev_lock = lock;
        end
    end

    // One lead window; caller is at a negedge. The leader is sampled at
    // cyc+1, the follower d cycles later; d=0 raises both together.
    task automatic window(input bit fb_leads, input int d);
        int s;
        s = cyc + 1;
        if (d == 0) begin
            ref_in = 1'b1;
            fb_in  = 1'b1;
        end else begin
            if (fb_leads) fb_in = 1'b1;
            else          ref_in = 1'b1;
            push_pulse(fb_leads ? 2'b10 : 2'b01, s + 3, d);
            repeat (d) @(negedge clk);
            ref_in = 1'b1;
            fb_in  = 1'b1;
        end
        repeat (4) @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        // Reset with both inputs high: outputs idle, and no edge after release.
        repeat (4) @(negedge clk);
        check("reset_instr", int'(instr), 0);
        check("reset_lock", int'(lock), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) @(negedge clk);

        window(1'b0, 7);
        window(1'b1, 3);
        window(1'b0, 0);

        // Cycle slip: second ref edge 20 cycles in, fb 25 cycles in.
        t0 = cyc + 1;
        ref_in = 1'b1;
        push_pulse(2'b01, t0 + 3, 25);
        repeat (5) @(negedge clk);
        ref_in = 1'b0;
        repeat (15) @(negedge clk);
        ref_in = 1'b1;
        repeat (5) @(negedge clk);
        fb_in = 1'b1;
        repeat (4) @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        repeat (6) @(negedge clk);

        // Clear mid-window: instruction drops on the edge that samples clear.
        t0 = cyc + 1;
        ref_in = 1'b1;
        push_pulse(2'b01, t0 + 3, 5);
        repeat (8) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        ref_in = 1'b0;
        repeat (6) @(negedge clk);

        // Sixteen 2-cycle windows; lock rises the cycle after the 16th closes.
        for (int i = 0; i < 16; i++) begin
`ifdef PFD_LOCK_DETECT_EN
            if (i == 15) push_lock(1'b1, cyc + 1 + 5);
`endif
            window(1'b0, 2);
        end

        // A 6-cycle window: error reaches 5 at t0+7, lock drops at t0+8.
`ifdef PFD_LOCK_DETECT_EN
        push_lock(1'b0, cyc + 1 + 8);
`endif
        window(1'b0, 6);

        repeat (10) @(negedge clk);
        check("pending_pulses", exp_q.size(), 0);
        check("pending_lock", lock_q.size(), 0);
        check("final_instr", int'(instr), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
